uart_rx_frame_buffer: RTL
=========================

Name: uart_rx_frame_buffer

Overview:
- Downstream consumer of the UART receiver FSM: takes its 9-bit data+parity word on each `ready` event, checks parity, and buffers the byte in a small show-ahead FIFO.
- Presents bytes to the host side with a valid/accept handshake; flags parity errors per byte and overruns sticky.
- Clocked by the receiver's 16x oversampling clock, so no CDC between receiver and buffer.

Parameters:
- DEPTH, 4: FIFO entries; power of 2, >= 2.
- ADDR_W, 2: log2(DEPTH).
- PARITY_ODD, 1: 1 = odd parity expected, 0 = even.

Ports:
- baudRateOut  input  1  clock (16x oversampling clock, shared with receiver FSM)
- rst  input  1  synchronous, active-high reset
- dataParityIn  input  9  receiver word; [7:0] data (bit0 = first data bit on line), [8] received parity bit
- rxReady  input  1  receiver ready; a rising edge marks a new valid dataParityIn
- dataOut  output  8  head-of-FIFO byte; 0 when empty
- dataErr  output  1  parity-error flag of head entry; 0 when empty
- dataValid  output  1  FIFO non-empty
- dataAccept  input  1  consumer pop request
- fifoCount  output  ADDR_W+1  current occupancy, 0..DEPTH
- overrunErr  output  1  sticky: a frame was lost to a full FIFO

Behaviour:
- Reset (rst=1 at a clock edge):
  - Pointers, fifoCount, dataValid, dataOut, dataErr and overrunErr all go to 0.
  - rxReadyD goes to 1, so a rxReady already high at reset release is not captured.
  - Any buffered entries are discarded; reset mid-operation has identical effect.
- Capture:
  - push = rxReady & ~rxReadyD; rxReadyD <= rxReady every cycle.
  - One push per rising edge regardless of how long rxReady stays high.
- Parity:
  - perr = (^dataParityIn[7:0] ^ dataParityIn[8]) ^ PARITY_ODD.
  - perr = 1 means mismatch. Example: 0x55 with parity bit 1 under odd parity gives perr = 0.
  - Computed combinationally in the push cycle; stored as {perr, data} (9 bits).
- Latency: push in cycle N → dataValid/dataOut/dataErr reflect the entry in cycle N+1 if the FIFO was empty. No combinational bypass.
- Pop: pop = dataValid & dataAccept. Head advances at the clock edge; dataAccept while empty is ignored.
- Simultaneous push and pop:
  - Not full: both happen, count unchanged.
  - Full: pop frees a slot, push writes it, no overrun.
  - Empty: only the push happens.
- Full with push and no pop: the new frame is dropped, overrunErr is set to 1, and FIFO contents are unchanged. overrunErr clears only on rst.
- Pointers: ADDR_W bits, wrap mod DEPTH. fifoCount is incremented/decremented, never exceeds DEPTH or goes below 0.
- dataOut/dataErr are driven from the mem[rdPtr] read, gated to 0 when fifoCount == 0.

Optional Feature:
- Macro: UART_RX_PARITY_DROP_EN.
- Defined:
  - A push with perr = 1 is not written; the FIFO and count are unchanged.
  - Extra output port dropCount (8 bits, reset 0) increments per dropped frame and saturates at 255.
  - dataErr is tied to 0.
  - The overrun check applies only to frames that would be written.
- Undefined: bad frames are stored with dataErr = 1 and the dropCount port does not exist.

Decomposition:
- Package uart_rx_pkg holds:
  - DATA_W = 8, PARITY_BIT = 8, FRAME_W = 9.
  - Entry type {err, data[7:0]}.
  - Parity function parity_ok(word, odd).
- Sub-module uart_sync_fifo: generic show-ahead synchronous FIFO (WIDTH, DEPTH) with push, pop, full, empty and count.
- Top level handles edge detect, parity, overrun and the drop counter.

Test Plan:
- Reset, then rxReady edge with dataParityIn = 9'h155 → next cycle dataValid = 1, dataOut = 8'h55, dataErr = 0, fifoCount = 1.
- rxReady edge with 9'h055 (0x55, parity 0, odd mode) → dataErr = 1. With UART_RX_PARITY_DROP_EN: fifoCount stays 0 and dataErr stays 0.
- rxReady held high for 5 cycles → exactly one entry (fifoCount = 1). rxReady high during and after rst deassert → no entry.
- 5 edges with dataAccept = 0 (DEPTH = 4), bytes 0x01..0x05 with correct parity:
  - fifoCount = 4 and overrunErr = 1.
  - Pops return 0x01..0x04; 0x05 is lost.
- Full FIFO, push edge coincident with dataAccept = 1 → fifoCount stays 4, overrunErr stays 0, new byte is last out.
- rst asserted with 3 entries buffered → next cycle dataValid = 0, fifoCount = 0, overrunErr = 0, dataOut = 0.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive frame buffer.
// Frame layout: [7:0] data (bit0 first on the line), [8] received parity bit.
package uart_rx_pkg;

    localparam int DATA_W     = 8;
    localparam int PARITY_BIT = 8;
    localparam int FRAME_W    = 9;

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] data;
    } entry_t;

    // Returns 1 when the received parity bit matches the expected sense.
    function automatic logic parity_ok(input logic [FRAME_W-1:0] word, input logic odd);
        return ~((^word[DATA_W-1:0]) ^ word[PARITY_BIT] ^ odd);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic show-ahead synchronous FIFO: rd_data always shows the head entry.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH  = 9,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem[rd_ptr_q];

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the gated head output hides stale entries.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_frame_buffer.sv
// Captures receiver words on rxReady rising edges, checks parity and buffers them.
// Build option UART_RX_PARITY_DROP_EN: drop bad-parity frames and count them on dropCount.
module uart_rx_frame_buffer
    import uart_rx_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = 2,
    parameter int PARITY_ODD = 1
) (
    input  logic               baudRateOut,
    input  logic               rst,
    input  logic [FRAME_W-1:0] dataParityIn,
    input  logic               rxReady,
    output logic [DATA_W-1:0]  dataOut,
    output logic               dataErr,
    output logic               dataValid,
    input  logic               dataAccept,
    output logic [ADDR_W:0]    fifoCount,
`ifdef UART_RX_PARITY_DROP_EN
    output logic               overrunErr,
    output logic [7:0]         dropCount
`else
    output logic               overrunErr
`endif
);

    logic   rx_ready_q;
    logic   overrun_q, overrun_d;
    logic   push, perr, wr_req, pop;
    logic   full, empty;
    entry_t wr_entry, head;

    assign push = rxReady & ~rx_ready_q;
    assign perr = ~parity_ok(dataParityIn, PARITY_ODD != 0);
    assign pop  = dataValid & dataAccept;

    assign wr_entry.err  = perr;
    assign wr_entry.data = dataParityIn[DATA_W-1:0];

`ifdef UART_RX_PARITY_DROP_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic       unused_head_err;

    assign wr_req          = push & ~perr;
    assign dataErr         = 1'b0;
    assign dropCount       = drop_cnt_q;
    assign unused_head_err = head.err;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (push && perr && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge baudRateOut) begin
        if (rst) drop_cnt_q <= '0;
        else     drop_cnt_q <= drop_cnt_d;
    end
`else
    assign wr_req  = push;
    assign dataErr = empty ? 1'b0 : head.err;
`endif

    // Overrun only when nothing leaves in the same cycle to make room.
    assign overrun_d = overrun_q | (wr_req & full & ~pop);

    always_ff @(posedge baudRateOut) begin
        if (rst) begin
            rx_ready_q <= 1'b1;
            overrun_q  <= 1'b0;
        end else begin
            rx_ready_q <= rxReady;
            overrun_q  <= overrun_d;
        end
    end

    uart_sync_fifo #(
        .WIDTH  (FRAME_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (baudRateOut),
        .rst     (rst),
        .push    (wr_req),
        .pop     (pop),
        .wr_data (wr_entry),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (fifoCount)
    );

    assign dataValid  = ~empty;
    assign dataOut    = empty ? '0 : head.data;
    assign overrunErr = overrun_q;

endmodule
